// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared constants for the LDM/STM block-transfer sequencer: FSM states,
// word size and the {up,pre} addressing-mode encodings.
package ldm_stm_sequencer_pkg;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // {up, pre}
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;

endpackage

// File: rtl/ldm_stm_sequencer_lsb_isolate16.sv
// Isolates the lowest set bit of a 16-bit vector; zero in gives zero out.
module lsb_isolate16 (
    input  logic [15:0] vec,
    output logic [15:0] onehot
);

    // Two's complement trick: x & -x keeps only the least significant one.
    assign onehot = vec & (~vec + 16'd1);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Block load/store sequencer: walks a register list in ascending order and
// presents one register/address pair per accepted transfer.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              up,
    input  logic              pre,
    output logic              busy,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic [15:0]       reg_onehot,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic              xfer_last,
    output logic              done,
    output logic [ADDR_W-1:0] wb_addr
);

    localparam logic [ADDR_W-1:0] Word = ADDR_W'(WORD_BYTES);

    logic [1:0]        state_q, state_d;
    logic [15:0]       mask_q, mask_d, lowest;
    logic [ADDR_W-1:0] addr_q, addr_d, wb_q, wb_d;
    logic [ADDR_W-1:0] span, start_addr;
    logic [4:0]        count;
    logic              in_xfer, single;

    lsb_isolate16 u_lsb (
        .vec    (mask_q),
        .onehot (lowest)
    );

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(reg_list[i]);
        end
    end

    assign span = ADDR_W'(count) * Word;

    // Transfers always run at ascending addresses, so decrement modes start low.
    always_comb begin
        case ({up, pre})
            MODE_IA: start_addr = base_addr;
            MODE_IB: start_addr = base_addr + Word;
            MODE_DA: start_addr = base_addr - span + Word;
            default: start_addr = base_addr - span;
        endcase
    end

    assign in_xfer = (state_q == ST_XFER);
    assign single  = (mask_q != 16'd0) && ((mask_q & (mask_q - 16'd1)) == 16'd0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        wb_d    = wb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = reg_list;
                    addr_d  = start_addr;
                    wb_d    = up ? (base_addr + span) : (base_addr - span);
                    state_d = (reg_list != 16'd0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (xfer_ready) begin
                    mask_d = mask_q & ~lowest;
                    addr_d = addr_q + Word;
                    if (single) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign xfer_valid = in_xfer;
    assign reg_onehot = in_xfer ? lowest : 16'd0;
    assign xfer_last  = in_xfer & single;
    assign xfer_addr  = addr_q;
    assign done       = (state_q == ST_DONE);
    assign wb_addr    = wb_q;

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: width of base, transfer and writeback addresses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin one block transfer; sampled only when busy=0.
REQ-005 reg_list  input  16  register list, bit i = register Ri participates.
REQ-006 base_addr  input  ADDR_W  base register value Rn.
REQ-007 up  input  1  1 = increment (IA/IB), 0 = decrement (DA/DB).
REQ-008 pre  input  1  1 = before (IB/DB), 0 = after (IA/DA).
REQ-009 busy  output  1  high from the cycle after start acceptance through the DONE cycle.
REQ-010 xfer_valid  output  1  a transfer is presented on reg_onehot/xfer_addr.
REQ-011 xfer_ready  input  1  memory side accepts the current transfer.
REQ-012 reg_onehot  output  16  one-hot register of the current transfer; feeds the downstream 16-to-4 encoder.
REQ-013 xfer_addr  output  ADDR_W  word address of the current transfer.
REQ-014 xfer_last  output  1  current transfer is the final one.
REQ-015 done  output  1  one-cycle pulse at end of the sequence.
REQ-016 wb_addr  output  ADDR_W  base writeback value; valid while done=1.

Function
REQ-017 FSM states IDLE, XFER, DONE.
REQ-018 IDLE and start=1: latch reg_list into remaining mask and compute n = popcount(reg_list) (0..16).
REQ-019 Start address: IA base; IB base+4; DA base-4n+4; DB base-4n; arithmetic modulo 2^ADDR_W.
REQ-020 wb_addr = base+4n if up, else base-4n; latched at start acceptance.
REQ-021 From IDLE, go to XFER next cycle if reg_list nonzero, otherwise to DONE (no transfers).
REQ-022 In XFER: xfer_valid=1; reg_onehot = lowest set bit of remaining mask; xfer_addr = current address.
REQ-023 Transfers occur in ascending register order at ascending addresses regardless of up/pre.
REQ-024 Transfer completes on a cycle with xfer_valid=1 and xfer_ready=1: clear that mask bit; address += 4.
REQ-025 While xfer_ready=0, reg_onehot, xfer_addr and xfer_last hold stable.
REQ-026 xfer_last = 1 when the remaining mask has exactly one set bit.
REQ-027 Completion of the last transfer moves to DONE next cycle; no idle cycle between transfers.
REQ-028 DONE lasts exactly one cycle: done=1, busy=1, then IDLE.
REQ-029 start while busy=1 is ignored; a start in the cycle DONE returns to IDLE is not accepted.
REQ-030 Outside XFER: xfer_valid=0, reg_onehot=0, xfer_last=0.
REQ-031 Latency: first transfer presented 1 cycle after start; n=0 gives done 1 cycle after start.

Reset
REQ-032 rst_n low forces IDLE immediately; busy, xfer_valid, xfer_last, done = 0; reg_onehot, xfer_addr, wb_addr, mask = 0.
REQ-033 Reset mid-sequence abandons remaining transfers; no done pulse is produced.

Structure
REQ-034 Shared package holds the FSM state enum, WORD_BYTES=4, and the {up,pre} mode encodings IA/IB/DA/DB.
REQ-035 Lowest-set-bit isolation is sub-module lsb_isolate16 (16-bit in, one-hot out, zero in gives zero out); popcount stays inline.

Verification
REQ-036 IA, base=0x1000, reg_list=0x000F, ready=1 -> onehot 0x1,0x2,0x4,0x8 at 0x1000..0x100C; last on 4th; done next cycle; wb=0x1010.
REQ-037 DB, base=0x2000, reg_list=0x8001 -> R0 @0x1FF8, R15 @0x1FFC; wb=0x1FF8.
REQ-038 IB, base=0x100, reg_list=0x0024, ready low 3 cycles on first transfer -> 0x04 @0x104 held stable, then 0x20 @0x108; wb=0x108.
REQ-039 reg_list=0x0000 -> no xfer_valid; done 1 cycle after start; wb_addr=base.
REQ-040 DA, base=0x0, reg_list=0xFFFF -> 16 transfers, R0 @0xFFFFFFC4 through R15 @0x0; wb=0xFFFFFFC0.
REQ-041 rst_n low during the 2nd transfer of list 0x00FF -> all outputs 0 immediately; no done; new start after release behaves normally.
